// File: rtl/uga_uart_pkg.sv
// Shared UART definitions used by the configurable receiver.
// Contents:
//   parity_t           parity selection (none / even / odd)
//   rx_state_t         receiver frame FSM states
//   OVERSAMPLE_DEF     ticks per bit (the scaler constant)
//   calc_prescaler()   clocks per oversample tick for a clock/baud pair
//   DIV_RESET_DEF      prescaler for 50 MHz / 38600 baud
//   data_bits_from_cfg() data-bit count (5..8) from the 2-bit config field
package uga_uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
  } rx_state_t;

  localparam int OVERSAMPLE_DEF = 8;

  function automatic int calc_prescaler(input int clk_hz, input int baud, input int os);
    return clk_hz / (baud * os);
  endfunction

  localparam int DIV_RESET_DEF = calc_prescaler(50_000_000, 38_600, OVERSAMPLE_DEF);

  function automatic logic [3:0] data_bits_from_cfg(input logic [1:0] cfg);
    return 4'd5 + {2'b00, cfg};
  endfunction

endpackage

// File: rtl/uart_rx_cfg_baud_tick.sv
// Oversample tick generator: a divisor counter that wraps at div_i-1
// (div_i = 0 behaves as 1) and can be synchronously cleared to realign
// the tick phase with a start edge.
// Ports:
//   clk, rst  system clock, synchronous active-high reset
//   clr_i     force counter to 0 on the next edge
//   div_i     clocks per tick
//   tick_o    high in the cycle the counter sits at its terminal value
module uart_rx_cfg_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] term;

  always_comb begin
    term   = (div_i == '0) ? '0 : div_i - DIV_W'(1);
    // >= so a divisor lowered below the current count still wraps promptly
    tick_o = (cnt_q >= term);
    cnt_d  = tick_o ? '0 : cnt_q + DIV_W'(1);
    if (clr_i) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5..8 data bits, none/even/odd parity,
// 1 or 2 stop bits, runtime baud divisor, 3-sample majority vote per bit,
// and a one-entry ready/valid holding register with overrun tracking.
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   rx_i                asynchronous serial input, idle high
//   cfg_div             clocks per oversample tick (0 acts as 1)
//   cfg_data_bits       data bits = 5 + value
//   cfg_parity          parity mode
//   cfg_two_stop        expect two stop bits
//   m_data/m_parity_err/m_frame_err/m_valid/m_ready  output word handshake
//   ovr_flag, ovr_clr   sticky overrun flag and its clear
//   break_det           one-cycle pulse on a break frame
//   busy                receiver is inside a frame
module uart_rx_cfg
  import uga_uart_pkg::*;
#(
  parameter int               OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int               DIV_W      = 16,
  parameter logic [DIV_W-1:0] DIV_RESET  = DIV_W'(DIV_RESET_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_i,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [1:0]       cfg_data_bits,
  input  parity_t          cfg_parity,
  input  logic             cfg_two_stop,
  output logic [7:0]       m_data,
  output logic             m_parity_err,
  output logic             m_frame_err,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             ovr_flag,
  input  logic             ovr_clr,
  output logic             break_det,
  output logic             busy
);

  localparam int SC_W = $clog2(OVERSAMPLE);
  localparam logic [SC_W-1:0] SC_S0   = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0] SC_S1   = SC_W'(OVERSAMPLE / 2);
  localparam logic [SC_W-1:0] SC_S2   = SC_W'(OVERSAMPLE / 2 + 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);

  rx_state_t        state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic             rxs_prev_q, rxs_prev_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [SC_W-1:0]  sc_q, sc_d;
  logic             smp0_q, smp0_d, smp1_q, smp1_d;
  logic [2:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [1:0]       nbits_q, nbits_d;
  parity_t          par_q, par_d;
  logic             two_q, two_d;
  logic             perr_q, perr_d, ferr_q, ferr_d, allz_q, allz_d, brk_q, brk_d;
  logic [7:0]       m_data_q, m_data_d;
  logic             m_perr_q, m_perr_d, m_ferr_q, m_ferr_d, m_valid_q, m_valid_d;
  logic             ovr_q, ovr_d, brk_out_q, brk_out_d;

  logic       rxs, tick, clr, start_edge, mid_tick, wrap_tick, maj;
  logic       frame_done, done_brk, done_ferr;
  logic [7:0] data_aligned;

  uart_rx_cfg_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (clr),
    .div_i  (div_q),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;  sync_d  = {sync_q[0], rx_i};
    sc_d    = sc_q;     smp0_d  = smp0_q;  smp1_d = smp1_q;
    bitcnt_d = bitcnt_q; shreg_d = shreg_q;
    nbits_d = nbits_q;  par_d   = par_q;   two_d  = two_q;
    perr_d  = perr_q;   ferr_d  = ferr_q;  allz_d = allz_q; brk_d = brk_q;
    m_data_d = m_data_q; m_perr_d = m_perr_q; m_ferr_d = m_ferr_q;
    m_valid_d = m_valid_q; ovr_d = ovr_q;
    clr = 1'b0; frame_done = 1'b0; done_brk = 1'b0; done_ferr = 1'b0;

    rxs        = sync_q[1];
    rxs_prev_d = rxs;
    // divisor only follows cfg_div between frames
    div_d      = (state_q == ST_IDLE) ? cfg_div : div_q;
    start_edge = rxs_prev_q & ~rxs;
    mid_tick   = tick && (sc_q == SC_S2);
    wrap_tick  = tick && (sc_q == SC_LAST);
    // third sample is the live rxs, taken in the same tick as the decision
    maj        = (smp0_q & smp1_q) | (smp0_q & rxs) | (smp1_q & rxs);
    // bits arrive LSB first into the top, so short words need right-aligning
    data_aligned = shreg_q >> (4'd8 - data_bits_from_cfg(nbits_q));

    if (tick) begin
      sc_d = (sc_q == SC_LAST) ? '0 : sc_q + SC_W'(1);
      if (sc_q == SC_S0) smp0_d = rxs;
      if (sc_q == SC_S1) smp1_d = rxs;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d  = ST_START;
          sc_d     = '0;
          clr      = 1'b1;
          nbits_d  = cfg_data_bits;
          par_d    = cfg_parity;
          two_d    = cfg_two_stop;
          bitcnt_d = '0;
          shreg_d  = '0;
          perr_d   = 1'b0;
          ferr_d   = 1'b0;
          allz_d   = 1'b1;
          brk_d    = 1'b0;
        end
      end
      ST_START: begin
        if (mid_tick && maj) state_d = ST_IDLE;
        else if (wrap_tick)  state_d = ST_DATA;
      end
      ST_DATA: begin
        if (mid_tick) begin
          shreg_d = {maj, shreg_q[7:1]};
          if (maj) allz_d = 1'b0;
        end
        if (wrap_tick) begin
          if (bitcnt_q == 3'(data_bits_from_cfg(nbits_q) - 4'd1))
            state_d = (par_q == PAR_NONE) ? ST_STOP1 : ST_PARITY;
          else
            bitcnt_d = bitcnt_q + 3'd1;
        end
      end
      ST_PARITY: begin
        if (mid_tick) begin
          if (maj) allz_d = 1'b0;
          if (((^data_aligned) ^ maj) != (par_q == PAR_ODD)) perr_d = 1'b1;
        end
        if (wrap_tick) state_d = ST_STOP1;
      end
      ST_STOP1: begin
        if (mid_tick) begin
          brk_d  = allz_q & ~maj;
          ferr_d = ferr_q | ~maj;
          // last stop bit leaves at its mid sample to catch an early next start
          if (!two_q) begin
            state_d    = ST_IDLE;
            frame_done = 1'b1;
            done_brk   = allz_q & ~maj;
            done_ferr  = ferr_q | ~maj;
          end
        end
        if (wrap_tick && two_q) state_d = ST_STOP2;
      end
      ST_STOP2: begin
        if (mid_tick) begin
          state_d    = ST_IDLE;
          frame_done = 1'b1;
          done_brk   = brk_q;
          done_ferr  = ferr_q | ~maj;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    brk_out_d = frame_done & done_brk;
    if (ovr_clr) ovr_d = 1'b0;
    if (frame_done) begin
      if (!m_valid_q || m_ready) begin
        m_valid_d = 1'b1;
        m_data_d  = data_aligned;
        m_perr_d  = perr_q;
        m_ferr_d  = done_ferr;
      end else begin
        ovr_d = 1'b1;  // overrun beats a same-cycle clear
      end
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;  sync_q <= 2'b11;  rxs_prev_q <= 1'b1;
      div_q   <= DIV_RESET; sc_q <= '0;  smp0_q <= 1'b1;  smp1_q <= 1'b1;
      bitcnt_q <= '0; shreg_q <= '0; nbits_q <= '0; par_q <= PAR_NONE; two_q <= 1'b0;
      perr_q <= 1'b0; ferr_q <= 1'b0; allz_q <= 1'b0; brk_q <= 1'b0;
      m_data_q <= '0; m_perr_q <= 1'b0; m_ferr_q <= 1'b0; m_valid_q <= 1'b0;
      ovr_q <= 1'b0;  brk_out_q <= 1'b0;
    end else begin
      state_q <= state_d;  sync_q <= sync_d;  rxs_prev_q <= rxs_prev_d;
      div_q   <= div_d;    sc_q <= sc_d;  smp0_q <= smp0_d;  smp1_q <= smp1_d;
      bitcnt_q <= bitcnt_d; shreg_q <= shreg_d; nbits_q <= nbits_d; par_q <= par_d; two_q <= two_d;
      perr_q <= perr_d; ferr_q <= ferr_d; allz_q <= allz_d; brk_q <= brk_d;
      m_data_q <= m_data_d; m_perr_q <= m_perr_d; m_ferr_q <= m_ferr_d; m_valid_q <= m_valid_d;
      ovr_q <= ovr_d;  brk_out_q <= brk_out_d;
    end
  end

  assign m_data       = m_data_q;
  assign m_parity_err = m_perr_q;
  assign m_frame_err  = m_ferr_q;
  assign m_valid      = m_valid_q;
  assign ovr_flag     = ovr_q;
  assign break_det    = brk_out_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
- Parametrised UART receiver, successor to the fixed 8N1 scaler/prescaler setup in the UART package.
- Adds runtime-selectable data bits (5..8), parity (none/even/odd), stop bits (1/2) and baud divisor.
- Adds majority-vote oversampling, error flags and a ready/valid output holding register.
- Sits between the FPGA pin (after the pad) and the servo-protocol packet parser.

Parameters:
- OVERSAMPLE, 8: ticks per bit; even, ≥4. Defaults to the package scaler constant.
- DIV_W, 16: width of the cfg_div baud divisor.
- DIV_RESET, 161: divisor value after reset; equals the package prescaler for 50 MHz / 38600 baud.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- rx_i  in  1  asynchronous serial line, idle high
- cfg_div  in  DIV_W  clocks per oversample tick; 0 treated as 1
- cfg_data_bits  in  2  data bits = 5 + value (0..3 → 5..8)
- cfg_parity  in  parity_t  none / even / odd
- cfg_two_stop  in  1  1 = two stop bits expected
- m_data  out  8  received word, LSB-aligned, unused MSBs 0
- m_parity_err  out  1  sideband, valid with m_data
- m_frame_err  out  1  sideband, a stop bit sampled 0
- m_valid  out  1  holding register full
- m_ready  in  1  consumer accepts
- ovr_flag  out  1  sticky overrun
- ovr_clr  in  1  clears ovr_flag
- break_det  out  1  one-cycle pulse on a break frame
- busy  out  1  FSM not IDLE

Behaviour:
- Reset values:
  - All outputs 0, except the synchroniser flops, which reset to 1.
  - FSM in IDLE; divisor counter 0.
- rx_i passes through a 2-flop synchroniser; rxs is the second flop's output.
- Tick generator:
  - Counter runs 0..max(cfg_div,1)-1; tick asserts in the cycle the counter equals the terminal value.
  - Counter is forced to 0 on start detection.
- Sub-bit counter sc runs 0..OVERSAMPLE-1 and advances on each tick.
- Bit value is the majority of rxs sampled at sc = OS/2-1, OS/2 and OS/2+1.
- FSM states: IDLE → START → DATA → PARITY → STOP1 → STOP2 → IDLE.
- IDLE:
  - A 1→0 transition of rxs moves the FSM to START and clears sc.
  - cfg_data_bits, cfg_parity and cfg_two_stop are latched on this transition; config changes mid-frame have no effect.
- START:
  - If the majority at sc = OS/2+1 is 1 (false start), return to IDLE with no output.
  - Otherwise continue to DATA at the sc wrap.
- DATA:
  - Bits shift in LSB first; the bit counter runs to the latched count minus 1.
  - Exit to PARITY if parity ≠ none, else to STOP1.
- PARITY:
  - Even: the XOR of data and parity bit must be 0.
  - Odd: that XOR must be 1.
  - A mismatch sets the pending parity_err.
- STOP1 / STOP2:
  - A sample of 0 sets the pending frame_err.
  - The final stop bit exits to IDLE at sc = OS/2+1, not at the bit end, so the next start edge is tracked early.
  - STOP2 is skipped when cfg_two_stop = 0.
- Write to the holding register happens in the exit cycle of the last stop bit:
  - m_valid, m_data and the error flags update on the next clock edge.
  - Latency: m_valid rises 1 clk after the final-stop mid sample.
- Holding register:
  - A write occurs if m_valid = 0, or if m_valid & m_ready in the same cycle (simultaneous pop and push is accepted).
  - Otherwise the new frame is dropped, ovr_flag is set and the held data is preserved.
  - Pop only: m_valid → 0 on the next edge; m_data retains its value.
- ovr_clr and a new overrun in the same cycle: set wins.
- break_det:
  - Pulses 1 clk when all data bits are 0, the parity bit (if any) is 0 and the first stop bit is 0.
  - The frame is still delivered with frame_err = 1.
- rst mid-frame: FSM returns to IDLE; partial frame discarded; m_valid and ovr_flag cleared.

Decomposition:
- Move to uga_uart_pkg:
  - parity_t
  - OVERSAMPLE default
  - prescaler computation
  - a function returning data-bit count from cfg_data_bits
  - a reset-divisor constant
- Natural sub-module: uart_baud_tick (divisor counter with sync clear, tick out).

Test Plan:
- 8N1 with cfg_div = 4 (32 clks/bit): send 0xA5 → m_data = 0xA5, no errors, m_valid rises 1 clk after the stop mid sample.
- 7E2: send 0x35 with correct parity 0, then 0x35 with parity 1 → first frame clean, second m_parity_err = 1 with m_data = 0x35.
- 3-clk-wide low glitch on idle rx_i → no m_valid, busy returns to 0 within 1 bit time.
- Hold m_ready = 0, send 0x11 then 0x22 → m_data stays 0x11, ovr_flag = 1; assert m_ready and ovr_clr → m_valid = 0, ovr_flag = 0.
- rx_i held low for 12 bit times (8N1) → break_det pulse, m_data = 0x00, m_frame_err = 1; later frame 0x5A received cleanly.
- Assert rst during DATA bit 3 of 0xFF → no m_valid; next frame 0x81 received correctly.
